// File: rtl/wc_pkg.sv
// Shared washing-machine control types: phase states, motor direction and
// nominal phase lengths the top-level sequencer passes in as Duration.
package wc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DWELL = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } phase_state_t;

  localparam logic FWD = 1'b0;
  localparam logic REV = 1'b1;

  localparam int WASH_DUR  = 600;
  localparam int RINSE_DUR = 300;
  localparam int DRY_DUR   = 900;

endpackage

// File: rtl/phase_tick_counter.sv
// Loadable up-counter with enable and clear; hit_next flags that the value
// about to be written on an enabled increment equals term.
module phase_tick_counter #(
  parameter int CNT_W = 10
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] count,
  output logic             hit_next
);

  logic [CNT_W-1:0] count_inc;

  assign count_inc = count + CNT_W'(1);
  assign hit_next  = (count_inc == term);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/drum_phase_ctrl.sv
// Drum-motor phase controller: times one wash/rinse/dry phase with optional
// periodic reversal separated by motor-off dwells, plus pause/resume.
//
// state | meaning
// IDLE  | waiting for Start; latches duration on Start
// RUN   | motor on, counting elapsed and segment ticks
// DWELL | motor off between direction segments, elapsed still counting
// HOLD  | paused; counters frozen, ret_state remembers where to resume
// DONE  | phase complete; Done held until Start drops
module drum_phase_ctrl
  import wc_pkg::*;
#(
  parameter int CNT_W       = 10,
  parameter int DEFAULT_DUR = 600,
  parameter int REV_PERIOD  = 60,
  parameter int DWELL_TICKS = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             Start,
  input  logic             Pause,
  input  logic             RevEn,
  input  logic [CNT_W-1:0] Duration,
  output logic             MotorOn,
  output logic             Reverse,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] Remaining
);

  localparam logic [CNT_W-1:0] DEF_DUR_C = CNT_W'(DEFAULT_DUR);
  localparam logic [CNT_W-1:0] REV_C     = CNT_W'(REV_PERIOD);
  localparam logic [CNT_W-1:0] DWELL_C   = CNT_W'(DWELL_TICKS);

  phase_state_t     state;
  phase_state_t     ret_state;
  phase_state_t     run_next;
  phase_state_t     dwell_next;
  logic [CNT_W-1:0] dur;
  logic [CNT_W-1:0] dur_sel;
  logic [CNT_W-1:0] rem_next;

  logic             el_clr;
  logic             el_en;
  logic [CNT_W-1:0] el_count;
  logic             el_hit_next;
  logic             seg_clr;
  logic             seg_en;
  logic [CNT_W-1:0] seg_count;
  logic [CNT_W-1:0] seg_term;
  logic             seg_hit_next;

  assign dur_sel  = (Duration == '0) ? DEF_DUR_C : Duration;
  assign seg_term = (state == DWELL) ? DWELL_C : REV_C;
  assign rem_next = dur - el_count - CNT_W'(1);

  // Counter steering: a segment boundary clears seg in the same edge that
  // changes state, so a pause on that edge resumes with a fresh segment.
  always_comb begin
    el_clr     = 1'b0;
    el_en      = 1'b0;
    seg_clr    = 1'b0;
    seg_en     = 1'b0;
    run_next   = (RevEn && seg_hit_next) ? DWELL : RUN;
    dwell_next = seg_hit_next ? RUN : DWELL;
    if (!Start) begin
      el_clr  = 1'b1;
      seg_clr = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          el_clr  = 1'b1;
          seg_clr = 1'b1;
        end
        RUN: begin
          el_en = 1'b1;
          if (!el_hit_next && run_next == DWELL) seg_clr = 1'b1;
          else                                   seg_en  = 1'b1;
        end
        DWELL: begin
          el_en = 1'b1;
          if (!el_hit_next && seg_hit_next) seg_clr = 1'b1;
          else                              seg_en  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  phase_tick_counter #(.CNT_W(CNT_W)) u_elapsed (
    .CLK      (CLK),
    .nRST     (nRST),
    .clr      (el_clr),
    .en       (el_en),
    .load     (1'b0),
    .load_val ('0),
    .term     (dur),
    .count    (el_count),
    .hit_next (el_hit_next)
  );

  phase_tick_counter #(.CNT_W(CNT_W)) u_segment (
    .CLK      (CLK),
    .nRST     (nRST),
    .clr      (seg_clr),
    .en       (seg_en),
    .load     (1'b0),
    .load_val ('0),
    .term     (seg_term),
    .count    (seg_count),
    .hit_next (seg_hit_next)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      ret_state <= IDLE;
      dur       <= '0;
      MotorOn   <= 1'b0;
      Reverse   <= FWD;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Remaining <= '0;
    end else if (!Start) begin
      state     <= IDLE;
      MotorOn   <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          dur       <= dur_sel;
          Remaining <= dur_sel;
          Reverse   <= FWD;
          MotorOn   <= 1'b1;
          Busy      <= 1'b1;
          Done      <= 1'b0;
          state     <= RUN;
        end
        RUN, DWELL: begin
          if (el_hit_next) begin
            state     <= DONE;
            MotorOn   <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            Remaining <= '0;
          end else begin
            Remaining <= rem_next;
            if (state == DWELL && seg_hit_next) begin
              Reverse <= (Reverse == FWD) ? REV : FWD;
            end
            if (Pause) begin
              state     <= HOLD;
              ret_state <= (state == RUN) ? run_next : dwell_next;
              MotorOn   <= 1'b0;
            end else begin
              state   <= (state == RUN) ? run_next : dwell_next;
              MotorOn <= (((state == RUN) ? run_next : dwell_next) == RUN);
            end
          end
        end
        HOLD: begin
          if (!Pause) begin
            state   <= ret_state;
            MotorOn <= (ret_state == RUN);
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drum_phase_ctrl.sv
// Bench for drum_phase_ctrl: directed scenarios and random stimulus, each
// cycle compared against a tick-based behavioural model of the phase.
module tb_drum_phase_ctrl;

  localparam int CNT_W = 10;
  localparam int DEF   = 600;
  localparam int RP    = 5;
  localparam int DW    = 2;

  logic             CLK = 1'b0;
  logic             nRST = 1'b0;
  logic             Start = 1'b0;
  logic             Pause = 1'b0;
  logic             RevEn = 1'b0;
  logic [CNT_W-1:0] Duration = '0;
  logic             MotorOn;
  logic             Reverse;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] Remaining;

  int checks = 0;
  int errors = 0;

  // model: phase 0 idle, 1 active (motor or dwell), 2 paused, 3 complete
  int   m_phase, m_dur, m_ticks, m_seg;
  bit   m_dwell;
  logic e_motor, e_rev, e_busy, e_done;
  int   e_rem;

  drum_phase_ctrl #(
    .CNT_W(CNT_W), .DEFAULT_DUR(DEF), .REV_PERIOD(RP), .DWELL_TICKS(DW)
  ) dut (
    .CLK(CLK), .nRST(nRST), .Start(Start), .Pause(Pause), .RevEn(RevEn),
    .Duration(Duration), .MotorOn(MotorOn), .Reverse(Reverse), .Busy(Busy),
    .Done(Done), .Remaining(Remaining)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_dur = 0; m_ticks = 0; m_seg = 0; m_dwell = 0;
    e_motor = 0; e_rev = 0; e_busy = 0; e_done = 0; e_rem = 0;
  endtask

  task automatic model_step();
    if (!Start) begin
      m_phase = 0; e_motor = 0; e_busy = 0; e_done = 0; e_rem = 0;
    end else begin
      case (m_phase)
        0: begin
          m_dur = (Duration == 0) ? DEF : int'(Duration);
          m_ticks = 0; m_seg = 0; m_dwell = 0; e_rev = 0;
          m_phase = 1; e_motor = 1; e_busy = 1; e_done = 0; e_rem = m_dur;
        end
        1: begin
          m_ticks++;
          m_seg++;
          if (m_ticks == m_dur) begin
            m_phase = 3; e_motor = 0; e_busy = 0; e_done = 1; e_rem = 0;
          end else begin
            e_rem = m_dur - m_ticks;
            if (!m_dwell && RevEn && m_seg == RP) begin
              m_dwell = 1; m_seg = 0;
            end else if (m_dwell && m_seg == DW) begin
              m_dwell = 0; m_seg = 0; e_rev = ~e_rev;
            end
            if (Pause) begin
              m_phase = 2; e_motor = 0;
            end else begin
              e_motor = !m_dwell;
            end
          end
        end
        2: if (!Pause) begin
          m_phase = 1; e_motor = !m_dwell;
        end
        default: ;
      endcase
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_step();
    #1;
    chk("motor", 32'(MotorOn), 32'(e_motor));
    chk("reverse", 32'(Reverse), 32'(e_rev));
    chk("busy", 32'(Busy), 32'(e_busy));
    chk("done", 32'(Done), 32'(e_done));
    chk("remaining", 32'(Remaining), 32'(e_rem));
  endtask

  task automatic run(input int n, output int mon, output int first_done);
    mon = 0;
    first_done = 0;
    for (int i = 1; i <= n; i++) begin
      cyc();
      if (MotorOn) mon++;
      if (Done && first_done == 0) first_done = i;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_motor"}, 32'(MotorOn), 0);
    chk({tag, "_rev"}, 32'(Reverse), 0);
    chk({tag, "_busy"}, 32'(Busy), 0);
    chk({tag, "_done"}, 32'(Done), 0);
    chk({tag, "_rem"}, 32'(Remaining), 0);
  endtask

  initial begin
    int mon, fd;
    model_reset();
    #12;
    chk_zero("reset");
    nRST = 1'b1;

    // full default-length phase, no reversal
    Duration = '0; RevEn = 1'b0; Start = 1'b1;
    run(605, mon, fd);
    chk("a_motor_cycles", 32'(mon), 600);
    chk("a_done_cycle", 32'(fd), 601);
    chk("a_done_hold", 32'(Done), 1);

    Start = 1'b0; cyc();
    chk("a_done_clear", 32'(Done), 0);

    // reversal pattern 5 on / 2 off
    Duration = 10'd20; RevEn = 1'b1; Start = 1'b1;
    run(24, mon, fd);
    chk("b_motor_cycles", 32'(mon), 15);
    chk("b_done_cycle", 32'(fd), 21);
    chk("b_reverse_end", 32'(Reverse), 0);
    Start = 1'b0; cyc();

    // pause after 4 ticks for 7 cycles
    Duration = 10'd10; RevEn = 1'b0; Start = 1'b1;
    fd = 0;
    for (int i = 1; i <= 22; i++) begin
      cyc();
      if (i >= 5 && i <= 11) begin
        chk("c_rem_frozen", 32'(Remaining), 6);
        chk("c_motor_off", 32'(MotorOn), 0);
      end
      if (Done && fd == 0) fd = i;
      if (i == 4)  Pause = 1'b1;
      if (i == 11) Pause = 1'b0;
    end
    chk("c_done_cycle", 32'(fd), 18);
    Start = 1'b0; cyc();

    // abort with Reverse set, then restart
    Duration = 10'd30; RevEn = 1'b1; Start = 1'b1;
    run(9, mon, fd);
    chk("d_rev_before_abort", 32'(Reverse), 1);
    Start = 1'b0; cyc();
    chk("d_busy_abort", 32'(Busy), 0);
    chk("d_done_abort", 32'(Done), 0);
    chk("d_rev_held", 32'(Reverse), 1);
    chk("d_no_done", 32'(fd), 0);
    Duration = 10'd10; RevEn = 1'b0; Start = 1'b1; cyc();
    chk("d_restart_rem", 32'(Remaining), 10);
    chk("d_restart_rev", 32'(Reverse), 0);
    Start = 1'b0; cyc();

    // pause arriving with completion
    Duration = 10'd7; Start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      if (i == 7) Pause = 1'b1;
    end
    chk("e_pause_done", 32'(Done), 1);
    chk("e_pause_busy", 32'(Busy), 0);
    Pause = 1'b0; Start = 1'b0; cyc();

    // completion inside the first dwell
    Duration = 10'd6; RevEn = 1'b1; Start = 1'b1;
    run(8, mon, fd);
    chk("f_dwell_done_cycle", 32'(fd), 7);
    chk("f_dwell_rev", 32'(Reverse), 0);
    Start = 1'b0; cyc();

    // async reset mid-run, Start held through release
    Duration = 10'd50; RevEn = 1'b1; Start = 1'b1;
    run(10, mon, fd);
    #2 nRST = 1'b0;
    #1 chk_zero("g_async");
    model_reset();
    nRST = 1'b1;
    cyc();
    chk("g_fresh_motor", 32'(MotorOn), 1);
    chk("g_fresh_rem", 32'(Remaining), 50);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      Start    = ($urandom_range(0, 99) < 96);
      Pause    = ($urandom_range(0, 99) < 12);
      RevEn    = ($urandom_range(0, 99) < 70);
      Duration = CNT_W'($urandom_range(1, 40));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
